// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory port plus the decode valid/ready handshake.
interface fetch_sequencer_if;
  logic [15:0] PC;
  logic [15:0] Instruction;
  logic        Redirect;
  logic [15:0] RedirectTarget;
  logic        Halt;
  logic        InstrValid;
  logic [15:0] InstrOut;
  logic [15:0] InstrPC;
  logic        InstrReady;
  logic [1:0]  Count;

  modport master (
    output PC, InstrValid, InstrOut, InstrPC, Count,
    input  Instruction, Redirect, RedirectTarget, Halt, InstrReady
  );

  modport slave (
    input  PC, InstrValid, InstrOut, InstrPC, Count,
    output Instruction, Redirect, RedirectTarget, Halt, InstrReady
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner and 2-entry fetch queue feeding decode.
// Operating mode (fetch / full / halted) follows directly from occupancy and Halt.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'd0,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input logic                Clock,
  input logic                Reset,
  fetch_sequencer_if.master  bus
);

  localparam logic [15:0] ResetPcAligned = RESET_PC & 16'hFFFE;

  logic [15:0] pc_q, pc_d;
  logic [15:0] head_instr_q, head_instr_d, head_pc_q, head_pc_d;
  logic [15:0] tail_instr_q, tail_instr_d, tail_pc_q, tail_pc_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  count_after_pop;
  logic        pop, push;

  always_comb begin
    pop  = (count_q != 2'd0) && bus.InstrReady && !bus.Redirect;
    push = !bus.Redirect && !bus.Halt && ((count_q != 2'd2) || pop);
    count_after_pop = count_q - {1'b0, pop};

    pc_d         = pc_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    count_d      = count_q;

    if (bus.Redirect) begin
      // Flush; slot contents are left alone so the head outputs hold their last value.
      count_d = 2'd0;
      pc_d    = {bus.RedirectTarget[15:1], 1'b0};
    end else begin
      // Only shift when a second entry exists, otherwise the stale head is kept.
      if (pop && (count_q == 2'd2)) begin
        head_instr_d = tail_instr_q;
        head_pc_d    = tail_pc_q;
      end
      if (push) begin
        if (count_after_pop == 2'd0) begin
          head_instr_d = bus.Instruction;
          head_pc_d    = pc_q;
        end else begin
          tail_instr_d = bus.Instruction;
          tail_pc_d    = pc_q;
        end
        pc_d = (pc_q + PC_STEP) & 16'hFFFE;
      end
      count_d = count_after_pop + {1'b0, push};
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q         <= ResetPcAligned;
      head_instr_q <= 16'd0;
      head_pc_q    <= 16'd0;
      tail_instr_q <= 16'd0;
      tail_pc_q    <= 16'd0;
      count_q      <= 2'd0;
    end else begin
      pc_q         <= pc_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
      count_q      <= count_d;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.InstrValid = (count_q != 2'd0);
  assign bus.InstrOut   = head_instr_q;
  assign bus.InstrPC    = head_pc_q;
  assign bus.Count      = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: expected decode stream is queued per scenario and
// consumed by a handshake monitor; scenario tasks check occupancy and PC inline.
module tb_fetch_sequencer;

  logic Clock = 1'b0;
  logic Reset;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC (16'd10),
    .PC_STEP  (16'd2)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb[$];
  logic [15:0] sb_exp;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  assign bus.Instruction = mem_word(bus.PC);

  // Scoreboard consumer: every accepted head must be the next expected address/word.
  always @(negedge Clock) begin
    if (!Reset && bus.InstrValid === 1'b1 && bus.InstrReady === 1'b1 && bus.Redirect === 1'b0)
    begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL accept_unexpected: got pc=%h instr=%h, none expected", bus.InstrPC,
                 bus.InstrOut);
      end else begin
        sb_exp = sb.pop_front();
        if (bus.InstrPC !== sb_exp || bus.InstrOut !== mem_word(sb_exp)) begin
          failures++;
          $display("FAIL accept_order: got pc=%h instr=%h want pc=%h instr=%h", bus.InstrPC,
                   bus.InstrOut, sb_exp, mem_word(sb_exp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset(input logic ready);
    Reset              = 1'b1;
    bus.Redirect       = 1'b0;
    bus.RedirectTarget = 16'd0;
    bus.Halt           = 1'b0;
    bus.InstrReady     = 1'b0;
    sb.delete();
    tick();
    tick();
    bus.InstrReady = ready;
    Reset          = 1'b0;
  endtask

  task automatic test_reset();
    Reset              = 1'b1;
    bus.Redirect       = 1'b0;
    bus.RedirectTarget = 16'd0;
    bus.Halt           = 1'b0;
    bus.InstrReady     = 1'b0;
    tick();
    checks++;
    if (bus.PC !== 16'h000A) begin
      failures++; $display("FAIL reset_pc: got %h want %h", bus.PC, 16'h000A);
    end
    checks++;
    if ({bus.InstrValid, bus.Count} !== 3'b000) begin
      failures++; $display("FAIL reset_valid_count: got %b want 000", {bus.InstrValid, bus.Count});
    end
    checks++;
    if ({bus.InstrOut, bus.InstrPC} !== 32'h0) begin
      failures++; $display("FAIL reset_head: got %h want 0", {bus.InstrOut, bus.InstrPC});
    end
  endtask

  task automatic test_stream();
    apply_reset(1'b1);
    for (int k = 0; k < 8; k++) sb.push_back(16'(10 + 2 * k));
    for (int k = 0; k < 8; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      checks++;
      if (bus.Count !== 2'd1 || bus.InstrValid !== 1'b1) begin
        failures++;
        $display("FAIL stream_count: got count=%0d valid=%b want 1/1", bus.Count, bus.InstrValid);
      end
      checks++;
      if (bus.PC !== 16'(12 + 2 * k)) begin
        failures++; $display("FAIL stream_pc: got %h want %h", bus.PC, 16'(12 + 2 * k));
      end
    end
    tick();
    bus.InstrReady = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL stream_drain: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_stall();
    apply_reset(1'b0);
    tick();
    @(negedge Clock);
    checks++;
    if (bus.Count !== 2'd1 || bus.InstrPC !== 16'd10) begin
      failures++;
      $display("FAIL stall_first: got count=%0d pc=%h want 1/000a", bus.Count, bus.InstrPC);
    end
    tick();
    @(negedge Clock);
    checks++;
    if (bus.Count !== 2'd2 || bus.PC !== 16'd14 || bus.InstrOut !== mem_word(16'd10)) begin
      failures++;
      $display("FAIL stall_full: got count=%0d pc=%h out=%h want 2/000e/%h", bus.Count, bus.PC,
               bus.InstrOut, mem_word(16'd10));
    end
    repeat (2) tick();
    @(negedge Clock);
    checks++;
    if (bus.Count !== 2'd2 || bus.PC !== 16'd14 || bus.InstrPC !== 16'd10) begin
      failures++;
      $display("FAIL stall_hold: got count=%0d pc=%h head=%h want 2/000e/000a", bus.Count,
               bus.PC, bus.InstrPC);
    end
    tick();
    bus.InstrReady = 1'b1;
    for (int k = 0; k < 6; k++) sb.push_back(16'(10 + 2 * k));
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      checks++;
      if (bus.Count !== 2'd2) begin
        failures++; $display("FAIL stall_drain_count: got %0d want 2", bus.Count);
      end
      tick();
    end
    bus.InstrReady = 1'b0;
    @(negedge Clock);
    checks++;
    if (sb.size() != 0 || bus.PC !== 16'd26) begin
      failures++;
      $display("FAIL stall_drain: got left=%0d pc=%h want 0/001a", sb.size(), bus.PC);
    end
  endtask

  task automatic test_redirect();
    apply_reset(1'b0);
    tick();
    tick();
    bus.Redirect       = 1'b1;
    bus.RedirectTarget = 16'h0041;
    bus.InstrReady     = 1'b1;
    sb.push_back(16'h0040);
    sb.push_back(16'h0042);
    tick();
    bus.Redirect = 1'b0;
    @(negedge Clock);
    checks++;
    if (bus.Count !== 2'd0 || bus.InstrValid !== 1'b0 || bus.PC !== 16'h0040) begin
      failures++;
      $display("FAIL redirect_flush: got count=%0d valid=%b pc=%h want 0/0/0040", bus.Count,
               bus.InstrValid, bus.PC);
    end
    tick();
    @(negedge Clock);
    checks++;
    if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 16'h0040) begin
      failures++;
      $display("FAIL redirect_target: got valid=%b pc=%h want 1/0040", bus.InstrValid, bus.InstrPC);
    end
    tick();
    @(negedge Clock);
    tick();
    bus.InstrReady = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL redirect_drain: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_halt();
    apply_reset(1'b0);
    tick();
    tick();
    bus.Halt       = 1'b1;
    bus.InstrReady = 1'b1;
    sb.push_back(16'd10);
    sb.push_back(16'd12);
    tick();
    @(negedge Clock);
    checks++;
    if (bus.Count !== 2'd1 || bus.PC !== 16'd14) begin
      failures++;
      $display("FAIL halt_drain: got count=%0d pc=%h want 1/000e", bus.Count, bus.PC);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge Clock);
      checks++;
      if (bus.Count !== 2'd0 || bus.InstrValid !== 1'b0 || bus.PC !== 16'd14) begin
        failures++;
        $display("FAIL halt_empty: got count=%0d valid=%b pc=%h want 0/0/000e", bus.Count,
                 bus.InstrValid, bus.PC);
      end
    end
    tick();
    bus.Halt = 1'b0;
    sb.push_back(16'd14);
    sb.push_back(16'd16);
    tick();
    @(negedge Clock);
    checks++;
    if (bus.Count !== 2'd1 || bus.InstrPC !== 16'd14 || bus.PC !== 16'd16) begin
      failures++;
      $display("FAIL halt_resume: got count=%0d head=%h pc=%h want 1/000e/0010", bus.Count,
               bus.InstrPC, bus.PC);
    end
    tick();
    @(negedge Clock);
    tick();
    bus.InstrReady = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL halt_sb: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    logic [15:0] wrap_pc [3];
    wrap_pc = '{16'hFFFE, 16'h0000, 16'h0002};
    apply_reset(1'b0);
    tick();
    bus.Redirect       = 1'b1;
    bus.RedirectTarget = 16'hFFFE;
    bus.InstrReady     = 1'b1;
    tick();
    bus.Redirect = 1'b0;
    for (int k = 0; k < 3; k++) sb.push_back(wrap_pc[k]);
    @(negedge Clock);
    checks++;
    if (bus.PC !== 16'hFFFE || bus.InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_load: got pc=%h valid=%b want fffe/0", bus.PC, bus.InstrValid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge Clock);
      checks++;
      if (bus.InstrPC !== wrap_pc[k] || bus.PC !== wrap_pc[k] + 16'd2) begin
        failures++;
        $display("FAIL wrap_seq: got head=%h pc=%h want %h/%h", bus.InstrPC, bus.PC, wrap_pc[k],
                 wrap_pc[k] + 16'd2);
      end
    end
    tick();
    bus.InstrReady = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL wrap_drain: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    apply_reset(1'b0);
    tick();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.PC !== 16'h000A || bus.InstrValid !== 1'b0 || bus.Count !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: got pc=%h valid=%b count=%0d want 000a/0/0", bus.PC,
               bus.InstrValid, bus.Count);
    end
    checks++;
    if ({bus.InstrOut, bus.InstrPC} !== 32'h0) begin
      failures++; $display("FAIL async_reset_head: got %h want 0", {bus.InstrOut, bus.InstrPC});
    end
    #1;
    Reset = 1'b0;
    tick();
    @(negedge Clock);
    checks++;
    if (bus.Count !== 2'd1 || bus.InstrPC !== 16'd10 || bus.PC !== 16'd12) begin
      failures++;
      $display("FAIL async_restart: got count=%0d head=%h pc=%h want 1/000a/000c", bus.Count,
               bus.InstrPC, bus.PC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
